id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register. Sits directly downstream of the immediate generator.
- Captures its sign-extended constant together with register operands, destination index, PC and control bits, and presents them to the EX stage.
- Owns load-use hazard detection: inserts a programmable number of bubbles and stalls fetch/decode.
- Also handles branch flush, downstream back-pressure, and a saturating stall-cycle counter.

---
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles, flush and stall counter
module id_ex_stage #(
   parameter int CTRL_W     = 10,
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [5:0]        id_rs,
   input  logic [5:0]        id_rt,
   input  logic [5:0]        id_rd,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic [31:0]       id_const,
   input  logic [31:0]       id_pc,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [5:0]        ex_rs,
   output logic [5:0]        ex_rt,
   output logic [5:0]        ex_rd,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_const,
   output logic [31:0]       ex_pc,
   output logic              stall_id,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int                BCNT_W    = 2;
   localparam logic [BCNT_W-1:0] BCNT_INIT = BCNT_W'(LU_BUBBLES - 1);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

   logic                valid_q, valid_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [5:0]          rs_q, rs_d;
   logic [5:0]          rt_q, rt_d;
   logic [5:0]          rd_q, rd_d;
   logic [31:0]         rs_data_q, rs_data_d;
   logic [31:0]         rt_data_q, rt_data_d;
   logic [31:0]         const_q, const_d;
   logic [31:0]         pc_q, pc_d;

   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                haz;
   logic                stall_c;
   logic                capture;

   // Load in EX whose destination feeds a source of the decode instruction.
   // During a bubble sequence the EX fields are held, so rd_q keeps the
   // load's destination index even though ex_valid is low.
   always_comb begin
      haz = valid_q & ctrl_q[1] & ctrl_q[0] & id_valid &
            ((id_rs == rd_q) | (id_rt == rd_q));
   end

   // Next-state and stall decision; flush overrides back-pressure and hazards.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      valid_d = valid_q;
      capture = 1'b0;
      stall_c = 1'b0;

      if (flush) begin
         state_d = ST_RUN;
         bcnt_d  = '0;
         valid_d = 1'b0;
      end else if (!ex_ready) begin
         stall_c = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (haz) begin
                  stall_c = 1'b1;
                  valid_d = 1'b0;
                  bcnt_d  = BCNT_INIT;
                  state_d = (LU_BUBBLES > 1) ? ST_BUBBLE : ST_RUN;
               end else begin
                  capture = 1'b1;
                  valid_d = id_valid;
               end
            end
            ST_BUBBLE: begin
               stall_c = 1'b1;
               valid_d = 1'b0;
               bcnt_d  = bcnt_q - 2'd1;
               // Leave once this bubble brings the count to zero.
               if (bcnt_q <= 2'd1) begin
                  bcnt_d  = '0;
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
               bcnt_d  = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // Payload fields load only on a normal advance; bubbles and flushes keep them.
   always_comb begin
      ctrl_d    = ctrl_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      const_d   = const_q;
      pc_d      = pc_q;
      if (capture) begin
         ctrl_d    = id_ctrl;
         rs_d      = id_rs;
         rt_d      = id_rt;
         rd_d      = id_rd;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         const_d   = id_const;
         pc_d      = id_pc;
      end
   end

   // Saturating count of cycles in which fetch/decode is held.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Hazard FSM state and remaining-bubble counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // EX slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         const_q   <= '0;
         pc_q      <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         const_q   <= const_d;
         pc_q      <= pc_d;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Stall is forced low while reset is held, even if ex_ready is low.
   assign stall_id   = rst_n & stall_c;
   assign stall_cnt  = cnt_q;

   assign ex_valid   = valid_q;
   assign ex_ctrl    = ctrl_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_rd      = rd_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_const   = const_q;
   assign ex_pc      = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   localparam int CW = 10;

   typedef struct packed {
      logic          v;
      logic [CW-1:0] ctrl;
      logic [5:0]    rs;
      logic [5:0]    rt;
      logic [5:0]    rd;
      logic [31:0]   rsd;
      logic [31:0]   rtd;
      logic [31:0]   cnst;
      logic [31:0]   pc;
   } ex_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          id_valid;
   logic [CW-1:0] id_ctrl;
   logic [5:0]    id_rs, id_rt, id_rd;
   logic [31:0]   id_rs_data, id_rt_data, id_const, id_pc;
   logic          flush, ex_ready;

   logic          a_ex_valid, b_ex_valid;
   logic [CW-1:0] a_ex_ctrl, b_ex_ctrl;
   logic [5:0]    a_ex_rs, a_ex_rt, a_ex_rd, b_ex_rs, b_ex_rt, b_ex_rd;
   logic [31:0]   a_ex_rs_data, a_ex_rt_data, a_ex_const, a_ex_pc;
   logic [31:0]   b_ex_rs_data, b_ex_rt_data, b_ex_const, b_ex_pc;
   logic          a_stall_id, b_stall_id;
   logic [15:0]   a_stall_cnt;
   logic [3:0]    b_stall_cnt;

   id_ex_stage #(.CTRL_W(CW), .LU_BUBBLES(1), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_const(id_const), .id_pc(id_pc),
      .flush(flush), .ex_ready(ex_ready),
      .ex_valid(a_ex_valid), .ex_ctrl(a_ex_ctrl), .ex_rs(a_ex_rs), .ex_rt(a_ex_rt), .ex_rd(a_ex_rd),
      .ex_rs_data(a_ex_rs_data), .ex_rt_data(a_ex_rt_data), .ex_const(a_ex_const), .ex_pc(a_ex_pc),
      .stall_id(a_stall_id), .stall_cnt(a_stall_cnt)
   );

   id_ex_stage #(.CTRL_W(CW), .LU_BUBBLES(3), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_const(id_const), .id_pc(id_pc),
      .flush(flush), .ex_ready(ex_ready),
      .ex_valid(b_ex_valid), .ex_ctrl(b_ex_ctrl), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt), .ex_rd(b_ex_rd),
      .ex_rs_data(b_ex_rs_data), .ex_rt_data(b_ex_rt_data), .ex_const(b_ex_const), .ex_pc(b_ex_pc),
      .stall_id(b_stall_id), .stall_cnt(b_stall_cnt)
   );

   bit          sel;
   ex_t         obs_a, obs_b, obs;
   logic        obs_stall;
   logic [15:0] obs_cnt;

   always_comb begin
      obs_a = {a_ex_valid, a_ex_ctrl, a_ex_rs, a_ex_rt, a_ex_rd,
               a_ex_rs_data, a_ex_rt_data, a_ex_const, a_ex_pc};
      obs_b = {b_ex_valid, b_ex_ctrl, b_ex_rs, b_ex_rt, b_ex_rd,
               b_ex_rs_data, b_ex_rt_data, b_ex_const, b_ex_pc};
      obs       = sel ? obs_b : obs_a;
      obs_stall = sel ? b_stall_id : a_stall_id;
      obs_cnt   = sel ? {12'd0, b_stall_cnt} : a_stall_cnt;
   end

   int  total = 0;
   int  bad   = 0;
   ex_t exp_q[$];
   ex_t held;

   task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic ex_t id_now();
      return {id_valid, id_ctrl, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_const, id_pc};
   endfunction

   task automatic set_id(input logic v, input logic [CW-1:0] c, input logic [5:0] rs,
                         input logic [5:0] rt, input logic [5:0] rd,
                         input logic [31:0] cn, input logic [31:0] pc);
      id_valid   = v;
      id_ctrl    = c;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_const   = cn;
      id_pc      = pc;
   endtask

   // Push the expected EX contents, check stall_id before the edge, pop and compare after it.
   task automatic step(input string tag, input ex_t e, input logic es);
      ex_t x;
      exp_q.push_back(e);
      #1;
      chk({tag, "_stall"}, 160'(obs_stall), 160'(es));
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      chk(tag, 160'(obs), 160'(x));
   endtask

   task automatic do_cap(input string tag);
      ex_t e;
      e = id_now();
      step(tag, e, 1'b0);
      held = e;
   endtask

   task automatic do_bub(input string tag, input logic es);
      ex_t e;
      e = held;
      e.v = 1'b0;
      step(tag, e, es);
      held = e;
   endtask

   task automatic do_hold(input string tag);
      step(tag, held, 1'b1);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      flush    = 1'b0;
      ex_ready = 1'b0;
      set_id(1'b0, '0, '0, '0, '0, '0, '0);
      #1;
      chk("rst_stall_a", 160'(a_stall_id), 160'(0));
      chk("rst_stall_b", 160'(b_stall_id), 160'(0));
      ex_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      held  = '0;
      chk("rst_ex", 160'(obs), 160'(0));
      chk("rst_cnt", 160'(obs_cnt), 160'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      // Phase A: single-bubble instance
      sel = 1'b0;
      do_reset();

      set_id(1'b1, 10'h001, 6'd1, 6'd2, 6'd3, 32'hFFFF_FFF6, 32'h10);
      do_cap("first_capture");
      chk("first_const", 160'(a_ex_const), 160'(32'hFFFF_FFF6));

      set_id(1'b1, 10'h003, 6'd7, 6'd8, 6'd5, 32'h0000_0004, 32'h14);
      do_cap("load_a");
      set_id(1'b1, 10'h001, 6'd5, 6'd9, 6'd10, 32'h8000_0000, 32'h18);
      do_bub("lu1_bubble", 1'b1);
      do_cap("lu1_consumer");
      chk("lu1_cnt", 160'(obs_cnt), 160'(1));

      set_id(1'b1, 10'h3F1, 6'd11, 6'd12, 6'd13, 32'h1234_5678, 32'h1C);
      ex_ready = 1'b0;
      repeat (4) do_hold("bp_hold");
      ex_ready = 1'b1;
      chk("bp_cnt", 160'(obs_cnt), 160'(5));
      do_cap("bp_release");

      set_id(1'b1, 10'h003, 6'd1, 6'd2, 6'd5, 32'h0, 32'h20);
      do_cap("load_b");
      set_id(1'b1, 10'h001, 6'd4, 6'd5, 6'd14, 32'h7, 32'h24);
      flush = 1'b1;
      do_bub("flush_haz", 1'b0);
      flush = 1'b0;
      do_cap("after_flush");
      chk("flush_cnt", 160'(obs_cnt), 160'(5));

      set_id(1'b1, 10'h003, 6'd1, 6'd2, 6'd6, 32'h0, 32'h28);
      do_cap("load_c");
      set_id(1'b1, 10'h001, 6'd6, 6'd3, 6'd15, 32'h9, 32'h2C);
      ex_ready = 1'b0;
      do_hold("haz_hold");
      ex_ready = 1'b1;
      do_bub("haz_after_hold", 1'b1);
      do_cap("haz_consumer");
      chk("haz_hold_cnt", 160'(obs_cnt), 160'(7));

      // Phase B: three-bubble instance with a 4-bit counter
      sel = 1'b1;
      do_reset();

      set_id(1'b1, 10'h003, 6'd1, 6'd2, 6'd5, 32'h0, 32'h40);
      do_cap("load_d");
      set_id(1'b1, 10'h001, 6'd6, 6'd5, 6'd16, 32'hFFFF_0000, 32'h44);
      do_bub("lu3_bub0", 1'b1);
      do_bub("lu3_bub1", 1'b1);
      do_bub("lu3_bub2", 1'b1);
      do_cap("lu3_consumer");
      chk("lu3_cnt", 160'(obs_cnt), 160'(3));

      set_id(1'b1, 10'h003, 6'd1, 6'd2, 6'd0, 32'h0, 32'h48);
      do_cap("load_r0");
      set_id(1'b1, 10'h001, 6'd0, 6'd7, 6'd17, 32'h5, 32'h4C);
      do_bub("r0_bub", 1'b1);
      flush = 1'b1;
      do_bub("flush_in_bubble", 1'b0);
      flush = 1'b0;
      do_cap("after_bubble_flush");
      chk("r0_cnt", 160'(obs_cnt), 160'(4));

      set_id(1'b1, 10'h003, 6'd1, 6'd2, 6'd5, 32'h0, 32'h50);
      ex_ready = 1'b0;
      repeat (11) do_hold("sat_hold");
      chk("sat_cnt_mid", 160'(obs_cnt), 160'(4'hF));
      repeat (9) do_hold("sat_hold");
      chk("sat_cnt_end", 160'(obs_cnt), 160'(4'hF));
      ex_ready = 1'b1;

      do_cap("load_e");
      set_id(1'b1, 10'h001, 6'd5, 6'd3, 6'd18, 32'h3, 32'h54);
      do_bub("pre_rst_bub", 1'b1);
      rst_n = 1'b0;
      #2;
      chk("async_rst_ex", 160'(obs), 160'(0));
      chk("async_rst_stall", 160'(obs_stall), 160'(0));
      chk("async_rst_cnt", 160'(obs_cnt), 160'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      held  = '0;
      #1;
      chk("post_rst_valid", 160'(obs.v), 160'(0));
      chk("post_rst_stall", 160'(obs_stall), 160'(0));
      do_cap("post_rst_capture");

      chk("sb_empty", 160'(exp_q.size()), 160'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
